bip_control: RTL and testbench

Instruction fetch/decode control unit for the accumulator processor. It drives the existing accumulator datapath by generating its select, write and ALU-operation controls plus the immediate operand. It also sequences program-memory fetches and data-memory read/write strobes. Each instruction executes in a fixed 3-state cycle (FETCH, DECODE, EXEC), from `i_start` until a HLT instruction.

---
 rtl/bip_control.sv | 136 +++++++++++++
 tb/tb_bip_control.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// Fetch/decode control unit for the accumulator processor; FETCH, DECODE, EXEC per instruction.
// Latency: 3 cycles per instruction. The program-memory read returns 1 cycle after o_PmAddr.
// No backpressure: memories must answer in fixed time, and HALT is left only by reset.
//
// Ports: i_clk/i_reset (async, active low), i_start, i_Instruction (program-memory data);
// o_PmAddr (PC), o_DmAddr/o_RdRam/o_WrRam (data memory), o_SelA/o_SelB/o_WrAcc/o_Op/o_Operand
// (datapath controls), o_halt.
module bip_control #(
   parameter int NBITS_PC  = 11,
   parameter int NBITS_OPC = 5,
   parameter int NBITS_O   = 11,
   parameter int NBITS_I   = NBITS_OPC + NBITS_O
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NBITS_I-1:0]  i_Instruction,
   output logic [NBITS_PC-1:0] o_PmAddr,
   output logic [NBITS_O-1:0]  o_DmAddr,
   output logic                o_RdRam,
   output logic                o_WrRam,
   output logic [1:0]          o_SelA,
   output logic                o_SelB,
   output logic                o_WrAcc,
   output logic                o_Op,
   output logic [NBITS_O-1:0]  o_Operand,
   output logic                o_halt
);

   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT} state_t;

   typedef struct packed {
      logic [1:0] sel_a;
      logic       sel_b;
      logic       op;
      logic       wr_acc;
      logic       wr_ram;
   } ctrl_t;

   localparam logic [NBITS_OPC-1:0] OPC_HLT  = NBITS_OPC'(0);
   localparam logic [NBITS_OPC-1:0] OPC_STO  = NBITS_OPC'(1);
   localparam logic [NBITS_OPC-1:0] OPC_LD   = NBITS_OPC'(2);
   localparam logic [NBITS_OPC-1:0] OPC_LDI  = NBITS_OPC'(3);
   localparam logic [NBITS_OPC-1:0] OPC_ADD  = NBITS_OPC'(4);
   localparam logic [NBITS_OPC-1:0] OPC_ADDI = NBITS_OPC'(5);
   localparam logic [NBITS_OPC-1:0] OPC_SUB  = NBITS_OPC'(6);
   localparam logic [NBITS_OPC-1:0] OPC_SUBI = NBITS_OPC'(7);

   // EXEC-cycle controls for one opcode; unlisted opcodes decode to all-zero (NOP).
   function automatic ctrl_t decode(input logic [NBITS_OPC-1:0] opc);
      ctrl_t c;
      c = '0;
      case (opc)
         OPC_STO:  c.wr_ram = 1'b1;
         OPC_LD:   c.wr_acc = 1'b1;
         OPC_LDI:  begin c.sel_a = 2'd1; c.wr_acc = 1'b1; end
         OPC_ADD:  begin c.sel_a = 2'd2; c.wr_acc = 1'b1; end
         OPC_ADDI: begin c.sel_a = 2'd2; c.sel_b = 1'b1; c.wr_acc = 1'b1; end
         OPC_SUB:  begin c.sel_a = 2'd2; c.op = 1'b1; c.wr_acc = 1'b1; end
         OPC_SUBI: begin c.sel_a = 2'd2; c.sel_b = 1'b1; c.op = 1'b1; c.wr_acc = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t               state_q, state_d;
   logic [NBITS_PC-1:0]  pc_q, pc_d;
   logic [NBITS_I-1:0]   ir_q, ir_d;
   ctrl_t                ctrl_q, ctrl_d;
   logic                 halt_q, halt_d;

   logic [NBITS_OPC-1:0] ir_opc, in_opc;
   assign ir_opc = ir_q[NBITS_I-1 -: NBITS_OPC];
   assign in_opc = i_Instruction[NBITS_I-1 -: NBITS_OPC];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ctrl_d  = '0;
      halt_d  = 1'b0;
      case (state_q)
         ST_IDLE:   if (i_start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            // IR and the EXEC controls load on the same edge, so the registered
            // controls always match the instruction held in IR during EXEC.
            ir_d    = i_Instruction;
            pc_d    = pc_q + NBITS_PC'(1);
            ctrl_d  = decode(in_opc);
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (ir_opc == OPC_HLT) begin
               state_d = ST_HALT;
               halt_d  = 1'b1;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALT:   halt_d = 1'b1;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         ctrl_q  <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ctrl_q  <= ctrl_d;
         halt_q  <= halt_d;
      end
   end

   // The read strobe must be valid in the same cycle the instruction arrives, so it
   // is decoded straight from the program-memory data rather than registered.
   assign o_RdRam   = (state_q == ST_DECODE) &&
                      (in_opc == OPC_LD || in_opc == OPC_ADD || in_opc == OPC_SUB);
   assign o_DmAddr  = (state_q == ST_DECODE) ? i_Instruction[NBITS_O-1:0] : ir_q[NBITS_O-1:0];
   assign o_PmAddr  = pc_q;
   assign o_Operand = ir_q[NBITS_O-1:0];
   assign o_SelA    = ctrl_q.sel_a;
   assign o_SelB    = ctrl_q.sel_b;
   assign o_Op      = ctrl_q.op;
   assign o_WrAcc   = ctrl_q.wr_acc;
   assign o_WrRam   = ctrl_q.wr_ram;
   assign o_halt    = halt_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench: program/data memory and accumulator datapath around bip_control.
// Cycle n = n-th rising edge after the edge that samples i_start (cycle 1 = first FETCH).
module tb_bip_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] instr;
   logic [10:0] pm_addr, dm_addr, operand;
   logic        rd_ram, wr_ram, sel_b, wr_acc, op, halt;
   logic [1:0]  sel_a;

   logic        start3 = 1'b0;
   logic [2:0]  pm3;
   logic [10:0] dm3, opnd3;
   logic        rd3, wr3, selb3, wracc3, op3, halt3;
   logic [1:0]  sela3;

   always #5 clk = ~clk;

   bip_control u_dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_Instruction(instr),
      .o_PmAddr(pm_addr), .o_DmAddr(dm_addr), .o_RdRam(rd_ram), .o_WrRam(wr_ram),
      .o_SelA(sel_a), .o_SelB(sel_b), .o_WrAcc(wr_acc), .o_Op(op),
      .o_Operand(operand), .o_halt(halt)
   );

   // Narrow-PC instance fed only NOPs (opcode 01000) for the wrap check.
   bip_control #(.NBITS_PC(3)) u_dut3 (
      .i_clk(clk), .i_reset(rst_n), .i_start(start3), .i_Instruction(16'h4000),
      .o_PmAddr(pm3), .o_DmAddr(dm3), .o_RdRam(rd3), .o_WrRam(wr3),
      .o_SelA(sela3), .o_SelB(selb3), .o_WrAcc(wracc3), .o_Op(op3),
      .o_Operand(opnd3), .o_halt(halt3)
   );

   // Memories and accumulator datapath model.
   logic [15:0] pmem [0:2047];
   logic [15:0] dmem [0:2047];
   logic [15:0] acc = 16'h0;
   logic [15:0] dm_rd = 16'h0;
   logic [15:0] bval;
   logic        poke = 1'b0;
   logic [10:0] poke_addr = '0;
   logic [15:0] poke_dat = '0;

   assign bval = sel_b ? {{5{operand[10]}}, operand} : dm_rd;

   always @(posedge clk) begin
      instr <= pmem[pm_addr];
      if (poke) dmem[poke_addr] <= poke_dat;
      if (rd_ram) dm_rd <= dmem[dm_addr];
      if (wr_ram) dmem[dm_addr] <= acc;
      if (wr_acc) begin
         case (sel_a)
            2'd0:    acc <= dm_rd;
            2'd1:    acc <= {{5{operand[10]}}, operand};
            default: acc <= op ? acc - bval : acc + bval;
         endcase
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample point: 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dm_poke(input logic [10:0] a, input logic [15:0] d);
      poke_addr = a; poke_dat = d; poke = 1'b1;
      step();
      poke = 1'b0;
   endtask

   // Reset, then pulse start; returns sampled in cycle 1 (first FETCH).
   task automatic start_prog();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   function automatic logic [6:0] strobes();
      return {rd_ram, wr_ram, wr_acc, sel_a, sel_b, op};
   endfunction

   initial begin
      for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;
      instr = 16'h0;

      // Reset state
      step();
      check("rst_pm_addr", 32'(pm_addr), 0);
      check("rst_strobes", 32'(strobes()), 0);
      check("rst_halt", 32'(halt), 0);
      check("rst_operand", 32'(operand), 0);
      check("rst_dm_addr", 32'(dm_addr), 0);

      // LDI 5; ADDI 3; STO 7; HLT
      pmem[0] = 16'h1805; pmem[1] = 16'h2803; pmem[2] = 16'h0807; pmem[3] = 16'h0000;
      start_prog();
      for (int c = 1; c <= 13; c++) begin
         check($sformatf("p1_wr_acc_c%0d", c), 32'(wr_acc), 32'(c == 3 || c == 6));
         check($sformatf("p1_wr_ram_c%0d", c), 32'(wr_ram), 32'(c == 9));
         check($sformatf("p1_rd_wr_excl_c%0d", c), 32'(rd_ram & wr_ram), 0);
         if (c == 9) check("p1_sto_dm_addr", 32'(dm_addr), 7);
         if (c == 12) check("p1_halt_c12", 32'(halt), 0);
         if (c < 13) step();
      end
      check("p1_halt_c13", 32'(halt), 1);
      check("p1_pc_after_hlt", 32'(pm_addr), 4);
      check("p1_acc", 32'(acc), 8);
      check("p1_mem7", 32'(dmem[7]), 8);

      // LD 2; SUB 3; HLT with mem[2]=10, mem[3]=4
      dm_poke(11'd2, 16'd10);
      dm_poke(11'd3, 16'd4);
      pmem[0] = 16'h1002; pmem[1] = 16'h3003; pmem[2] = 16'h0000;
      start_prog();
      for (int c = 1; c <= 7; c++) begin
         check($sformatf("p2_rd_ram_c%0d", c), 32'(rd_ram), 32'(c == 2 || c == 5));
         if (c == 2) check("p2_ld_dm_addr", 32'(dm_addr), 2);
         if (c == 5) check("p2_sub_dm_addr", 32'(dm_addr), 3);
         // {rd,wr,wr_acc,sel_a,sel_b,op}
         if (c == 3) check("p2_ld_exec", 32'(strobes()), 32'(7'b0010000));
         if (c == 6) check("p2_sub_exec", 32'(strobes()), 32'(7'b0011001));
         step();
      end
      check("p2_acc", 32'(acc), 6);

      // LDI 0; SUBI 0x7FF (-1)
      pmem[0] = 16'h1800; pmem[1] = 16'h3FFF; pmem[2] = 16'h0000;
      start_prog();
      for (int c = 1; c <= 7; c++) begin
         if (c == 6) begin
            check("p3_subi_operand", 32'(operand), 32'h7FF);
            check("p3_subi_exec", 32'(strobes()), 32'(7'b0011011));
         end
         step();
      end
      check("p3_acc", 32'(acc), 1);

      // Unused opcodes 01000 and 11111 act as NOPs
      pmem[0] = 16'h4000; pmem[1] = 16'hF800; pmem[2] = 16'h0000;
      start_prog();
      for (int c = 1; c <= 7; c++) begin
         if (c <= 6) check($sformatf("p4_nop_strobes_c%0d", c), 32'(strobes()), 0);
         if (c == 4) check("p4_pc_after_nop1", 32'(pm_addr), 1);
         if (c == 7) check("p4_pc_after_nop2", 32'(pm_addr), 2);
         if (c < 7) step();
      end

      // Asynchronous reset during EXEC of STO 5
      dm_poke(11'd5, 16'hAAAA);
      pmem[0] = 16'h0805;
      start_prog();
      step(); step();
      check("p5_sto_wr_ram", 32'(wr_ram), 1);
      #2 rst_n = 1'b0;
      #1;
      check("p5_rst_wr_ram", 32'(wr_ram), 0);
      check("p5_rst_pc", 32'(pm_addr), 0);
      step();
      rst_n = 1'b1;
      repeat (4) step();
      check("p5_idle_pc", 32'(pm_addr), 0);
      check("p5_idle_strobes", 32'(strobes()), 0);
      check("p5_mem5_kept", 32'(dmem[5]), 32'hAAAA);

      // i_start held high in HALT does not restart
      pmem[0] = 16'h0000;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      start = 1'b1;
      step();
      step(); step(); step();
      check("p6_halt_c4", 32'(halt), 1);
      repeat (10) step();
      check("p6_halt_held", 32'(halt), 1);
      check("p6_pc_held", 32'(pm_addr), 1);
      check("p6_strobes", 32'(strobes()), 0);
      start = 1'b0;

      // PC wrap on the 3-bit instance: 8 NOPs, then PC back to 0
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         if (c == 22) check("p7_pc_fetch7", 32'(pm3), 7);
         if (c == 25) check("p7_pc_wrap", 32'(pm3), 0);
         if (c < 25) step();
      end
      check("p7_halt", 32'(halt3), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
